pm_exec_seq: RTL and testbench
==============================

Name: pm_exec_seq

Overview:
Instruction sequencer that reads program-memory words and drives the data-memory strobes. It is the consuming end of the PM word interface: it drives ld_inst / ld_val_reg and a PM address, captures the instruction and address buses, and steps each instruction through fetch and execute phases. It sits between the PM word array and the DM word array, replacing hand-driven strobes in the top level.

Parameters:
PC_RESET, 16'h0000, program counter value after reset
AW, 16, PM address width (fixed at 16; the parameter exists for documentation only)

Ports:
clk  input  1  system clock, rising edge
clr  input  1  synchronous reset, active-low
run  input  1  level; 1 = keep fetching, 0 = stop at the next instruction boundary
instruction  input  16  instruction bus from the PM words (valid while ld_inst=1)
addbus_in  input  16  address bus from the PM words (operand capture for JMP)
pm_addr  output  16  PM word select address
ld_inst  output  1  PM output enable
ld_val_reg  output  3  PM field select: 0 val, 1 reg1, 2 reg2, 3 reg3, 4 val+reg3, 5 address, 7 none
dm_rd  output  1  DM read strobe
dm_rd_latch  output  1  DM read-latch hold
dm_wr  output  1  DM write strobe
halted  output  1  1 after HLT until reset
illegal  output  1  one-cycle pulse on an undefined opcode

Behaviour:
- Internal registers: pc[15:0], ia[15:0] (address of the current instruction word), ir[15:0], and a state register.
- States: IDLE, FETCH, EX1, EX2, HALT.
- Reset (clr=0 at a clock edge, in any state):
  - state=IDLE, pc=PC_RESET, ia=PC_RESET, ir=0.
  - ld_inst=0, ld_val_reg=7, dm_rd=0, dm_rd_latch=0, dm_wr=0, halted=0, illegal=0.
  - A reset in the middle of an instruction aborts it; no strobe is asserted in the cycle after reset.
- All outputs are decoded from registered state/ir/ia/pc. There is no combinational path from the inputs to the outputs.
- Opcode = ir[15:11]: 0 NOP, 1 MOVI, 2 MOV, 3 JMP, 4 HLT; all other values are illegal.
- IDLE: all strobes low, ld_val_reg=7. If run=1, go to FETCH next cycle.
- FETCH (1 cycle):
  - Outputs: pm_addr=pc, ld_inst=1, ld_val_reg=7.
  - At the edge: ir<=instruction, ia<=pc, pc<=pc+1 (mod 2^16, FFFF wraps to 0000). Go to EX1.
- EX1, by opcode:
  - NOP: no strobes. Go to the next-instruction step.
  - MOVI: pm_addr=ia, ld_inst=1, ld_val_reg=4, dm_wr=1. Go to the next-instruction step.
  - MOV: pm_addr=ia, ld_inst=1, ld_val_reg=1, dm_rd=1, dm_rd_latch=1. Go to EX2.
  - JMP: pm_addr=pc (the operand word), ld_inst=1, ld_val_reg=5. At the edge pc<=addbus_in. Go to the next-instruction step.
  - HLT: no strobes. Go to HALT.
  - Illegal: illegal=1 for this cycle, otherwise behaves as NOP.
- EX2 (MOV only): pm_addr=ia, ld_inst=1, ld_val_reg=2, dm_rd_latch=1, dm_wr=1, dm_rd=0. Go to the next-instruction step.
- Next-instruction step: go to FETCH if run=1, else IDLE. run is sampled only at this step and in IDLE; deasserting run mid-instruction does not abort the instruction.
- HALT: halted=1, all strobes low, ld_val_reg=7. Only reset leaves this state; run is ignored.
- Instruction latency: NOP/MOVI/JMP/illegal take 2 cycles, MOV takes 3, HLT takes 2 and then stays in HALT. Back-to-back issue has no bubble.
- JMP at ia=FFFE: operand word at FFFF. JMP at ia=FFFF: operand word at 0000 (wrapped pc).
- dm_wr and dm_rd are never both 1 in the same cycle. When ld_inst=0, ld_val_reg is always 7.

Test Plan:
- Reset/idle: clr=0 for 2 cycles, run=0 -> pc=0000, all strobes 0, ld_val_reg=7, halted=0. Raise run -> FETCH with pm_addr=0000, ld_inst=1 exactly one cycle later.
- MOVI: PM[0]=16'h0A5C (op1) -> FETCH at 0000, then EX1 with pm_addr=0000, ld_val_reg=4, dm_wr=1 for exactly 1 cycle; next FETCH at 0001.
- MOV: PM[0]=16'h1000|reg fields -> EX1 ld_val_reg=1, dm_rd=1, dm_rd_latch=1; EX2 ld_val_reg=2, dm_wr=1, dm_rd_latch=1, dm_rd=0. Total 3 cycles; no cycle with dm_rd=dm_wr=1.
- JMP with wrap: pc preset to FFFF via PC_RESET=16'hFFFF, PM[FFFF]=16'h1800, addbus_in=16'h0040 during EX1 -> EX1 pm_addr=0000, ld_val_reg=5; next FETCH pm_addr=0040.
- Illegal then HLT: PM[0]=16'hF800, PM[1]=16'h2000 -> illegal pulses 1 cycle in EX1 of word 0; after word 1, halted=1 and stays 1 with run=1 for 20 cycles, pm_addr frozen, no strobes.
- Reset mid-MOV: assert clr=0 in EX1 of MOV -> next cycle dm_wr=0, dm_rd=0, state IDLE, pc=PC_RESET; run=1 restarts from PC_RESET. Also: dropping run during EX1 of MOV -> EX2 still completes, then IDLE.

Source files
------------

// File: rtl/pm_exec_seq.sv
// pm_exec_seq: program-memory instruction sequencer driving PM field selects and DM strobes.
module pm_exec_seq #(
  parameter logic [15:0] PC_RESET = 16'h0000,
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          run,
  input  logic [15:0]   instruction,
  input  logic [AW-1:0] addbus_in,
  output logic [AW-1:0] pm_addr,
  output logic          ld_inst,
  output logic [2:0]    ld_val_reg,
  output logic          dm_rd,
  output logic          dm_rd_latch,
  output logic          dm_wr,
  output logic          halted,
  output logic          illegal
);
  typedef enum logic [2:0] {IDLE, FETCH, EX1, EX2, HALT} state_t;
  localparam logic [4:0] OP_MOVI = 5'd1, OP_MOV = 5'd2, OP_JMP = 5'd3, OP_HLT = 5'd4;
  state_t state, nxt;
  logic [AW-1:0] pc, ia;
  logic [15:0] ir;
  logic [4:0] op;
  logic ex1;
  assign op = ir[15:11];
  assign ex1 = state == EX1;
  always_ff @(posedge clk) begin
    if (!clr) begin
      state <= IDLE;
      pc <= PC_RESET;
      ia <= PC_RESET;
      ir <= '0;
    end else begin
      state <= nxt;
      if (state == FETCH) begin
        ir <= instruction;
        ia <= pc;
        pc <= pc + 1'b1;
      end else if (ex1 && op == OP_JMP) pc <= addbus_in;
    end
  end
  // run is only honoured at instruction boundaries so an in-flight instruction always completes
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = run ? FETCH : IDLE;
      FETCH:   nxt = EX1;
      EX1:     nxt = op == OP_HLT ? HALT : op == OP_MOV ? EX2 : run ? FETCH : IDLE;
      EX2:     nxt = run ? FETCH : IDLE;
      HALT:    nxt = HALT;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    pm_addr = ((ex1 && (op == OP_MOVI || op == OP_MOV)) || state == EX2) ? ia : pc;
    ld_inst = state == FETCH || state == EX2 || (ex1 && (op == OP_MOVI || op == OP_MOV || op == OP_JMP));
    ld_val_reg = state == EX2 ? 3'd2 : !ex1 ? 3'd7 : op == OP_MOVI ? 3'd4 :
                 op == OP_MOV ? 3'd1 : op == OP_JMP ? 3'd5 : 3'd7;
    dm_rd = ex1 && op == OP_MOV;
    dm_rd_latch = (ex1 && op == OP_MOV) || state == EX2;
    dm_wr = (ex1 && op == OP_MOVI) || state == EX2;
    halted = state == HALT;
    illegal = ex1 && op > OP_HLT;
  end
endmodule

// File: tb/tb_pm_exec_seq.sv
// tb_pm_exec_seq: directed and random checks of pm_exec_seq against an instruction-level trace model.
module tb_pm_exec_seq;
  logic clk = 0, clr = 0, run = 0;
  logic [15:0] pm [0:65535];
  logic [15:0] ab [0:65535];
  logic [15:0] pa1, pa2, ins1, ins2, ad1, ad2;
  logic li1, li2, rd1, rd2, rl1, rl2, wr1, wr2, h1, h2, il1, il2;
  logic [2:0] lv1, lv2;
  logic [24:0] v1, v2;
  int n_cmp = 0, n_bad = 0;

  assign ins1 = pm[pa1];
  assign ad1 = ab[pa1];
  assign ins2 = pm[pa2];
  assign ad2 = ab[pa2];
  assign v1 = {pa1, li1, lv1, rd1, rl1, wr1, h1, il1};
  assign v2 = {pa2, li2, lv2, rd2, rl2, wr2, h2, il2};

  pm_exec_seq dut (.clk(clk), .clr(clr), .run(run), .instruction(ins1), .addbus_in(ad1),
    .pm_addr(pa1), .ld_inst(li1), .ld_val_reg(lv1), .dm_rd(rd1), .dm_rd_latch(rl1),
    .dm_wr(wr1), .halted(h1), .illegal(il1));
  pm_exec_seq #(.PC_RESET(16'hFFFF)) dut2 (.clk(clk), .clr(clr), .run(run), .instruction(ins2),
    .addbus_in(ad2), .pm_addr(pa2), .ld_inst(li2), .ld_val_reg(lv2), .dm_rd(rd2),
    .dm_rd_latch(rl2), .dm_wr(wr2), .halted(h2), .illegal(il2));

  always #5 clk = ~clk;

  function automatic logic [24:0] ev(input logic [15:0] a, input logic li, input logic [2:0] lv,
                                     input logic rd, input logic rl, input logic wr,
                                     input logic h, input logic il);
    return {a, li, lv, rd, rl, wr, h, il};
  endfunction

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset;
    clr = 0;
    run = 0;
    step();
    step();
  endtask

  task automatic test_reset;
    logic [24:0] e;
    do_reset();
    e = ev(16'h0, 0, 3'd7, 0, 0, 0, 0, 0);
    n_cmp++;
    if ((v1 & 25'h1FF) !== e) begin n_bad++; $display("FAIL reset: got %h want %h", v1 & 25'h1FF, e); end
    n_cmp++;
    if ((v2 & 25'h1FF) !== e) begin n_bad++; $display("FAIL reset2: got %h want %h", v2 & 25'h1FF, e); end
    clr = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if ((v1 & 25'h1FF) !== e) begin n_bad++; $display("FAIL idle cyc %0d: got %h want %h", i, v1 & 25'h1FF, e); end
    end
    run = 1;
    step();
    e = ev(16'h0000, 1, 3'd7, 0, 0, 0, 0, 0);
    n_cmp++;
    if (v1 !== e) begin n_bad++; $display("FAIL first_fetch: got %h want %h", v1, e); end
    e = ev(16'hFFFF, 1, 3'd7, 0, 0, 0, 0, 0);
    n_cmp++;
    if (v2 !== e) begin n_bad++; $display("FAIL first_fetch2: got %h want %h", v2, e); end
  endtask

  task automatic test_movi;
    logic [24:0] e [4];
    logic [24:0] m;
    pm[0] = 16'h0A5C; pm[1] = 16'h0000; pm[2] = 16'h0000;
    e = '{ev(16'h0, 1, 3'd7, 0, 0, 0, 0, 0), ev(16'h0, 1, 3'd4, 0, 0, 1, 0, 0),
          ev(16'h1, 1, 3'd7, 0, 0, 0, 0, 0), ev(16'h0, 0, 3'd7, 0, 0, 0, 0, 0)};
    do_reset();
    clr = 1; run = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      m = e[i][8] ? '1 : 25'h1FF;
      n_cmp++;
      if ((v1 & m) !== (e[i] & m)) begin n_bad++; $display("FAIL movi cyc %0d: got %h want %h", i, v1 & m, e[i] & m); end
    end
  endtask

  task automatic test_mov;
    logic [24:0] e [4];
    pm[0] = 16'h1123; pm[1] = 16'h0000;
    e = '{ev(16'h0, 1, 3'd7, 0, 0, 0, 0, 0), ev(16'h0, 1, 3'd1, 1, 1, 0, 0, 0),
          ev(16'h0, 1, 3'd2, 0, 1, 1, 0, 0), ev(16'h1, 1, 3'd7, 0, 0, 0, 0, 0)};
    do_reset();
    clr = 1; run = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if (v1 !== e[i] || (rd1 && wr1)) begin n_bad++; $display("FAIL mov cyc %0d: got %h want %h", i, v1, e[i]); end
    end
  endtask

  task automatic test_jmp_wrap;
    logic [24:0] e [3];
    pm[16'hFFFF] = 16'h1800; ab[16'h0000] = 16'h0040; pm[16'h0040] = 16'h0000;
    e = '{ev(16'hFFFF, 1, 3'd7, 0, 0, 0, 0, 0), ev(16'h0000, 1, 3'd5, 0, 0, 0, 0, 0),
          ev(16'h0040, 1, 3'd7, 0, 0, 0, 0, 0)};
    do_reset();
    clr = 1; run = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (v2 !== e[i]) begin n_bad++; $display("FAIL jmp_wrap cyc %0d: got %h want %h", i, v2, e[i]); end
    end
  endtask

  task automatic test_illegal_hlt;
    logic [24:0] e [4];
    logic [24:0] m, eh;
    logic [15:0] frz;
    pm[0] = 16'hF800; pm[1] = 16'h2000;
    e = '{ev(16'h0, 1, 3'd7, 0, 0, 0, 0, 0), ev(16'h0, 0, 3'd7, 0, 0, 0, 0, 1),
          ev(16'h1, 1, 3'd7, 0, 0, 0, 0, 0), ev(16'h0, 0, 3'd7, 0, 0, 0, 0, 0)};
    eh = ev(16'h0, 0, 3'd7, 0, 0, 0, 1, 0);
    frz = '0;
    do_reset();
    clr = 1; run = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      m = e[i][8] ? '1 : 25'h1FF;
      n_cmp++;
      if ((v1 & m) !== (e[i] & m)) begin n_bad++; $display("FAIL ill_hlt cyc %0d: got %h want %h", i, v1 & m, e[i] & m); end
    end
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 0) frz = pa1;
      n_cmp++;
      if ((v1 & 25'h1FF) !== eh || pa1 !== frz) begin
        n_bad++; $display("FAIL halt cyc %0d: got %h addr %h want %h addr %h", i, v1 & 25'h1FF, pa1, eh, frz);
      end
    end
  endtask

  task automatic test_reset_mid_mov;
    logic [24:0] idle, f0, ex2;
    idle = ev(16'h0, 0, 3'd7, 0, 0, 0, 0, 0);
    f0 = ev(16'h0, 1, 3'd7, 0, 0, 0, 0, 0);
    ex2 = ev(16'h0, 1, 3'd2, 0, 1, 1, 0, 0);
    pm[0] = 16'h1123; pm[1] = 16'h0000;
    do_reset();
    clr = 1; run = 1;
    step();
    step();
    n_cmp++;
    if (rd1 !== 1'b1) begin n_bad++; $display("FAIL midmov_ex1 rd: got %b want 1", rd1); end
    clr = 0;
    step();
    n_cmp++;
    if ((v1 & 25'h1FF) !== idle) begin n_bad++; $display("FAIL midmov_abort: got %h want %h", v1 & 25'h1FF, idle); end
    clr = 1;
    step();
    n_cmp++;
    if (v1 !== f0) begin n_bad++; $display("FAIL midmov_restart: got %h want %h", v1, f0); end
    do_reset();
    clr = 1; run = 1;
    step();
    step();
    run = 0;
    step();
    n_cmp++;
    if (v1 !== ex2) begin n_bad++; $display("FAIL rundrop_ex2: got %h want %h", v1, ex2); end
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++;
      if ((v1 & 25'h1FF) !== idle) begin n_bad++; $display("FAIL rundrop_idle cyc %0d: got %h want %h", i, v1 & 25'h1FF, idle); end
    end
  endtask

  task automatic test_random;
    logic [24:0] q [$];
    logic [24:0] m;
    logic [15:0] p, w;
    logic [4:0] op;
    int r;
    for (int round = 0; round < 3; round++) begin
      for (int i = 0; i < 512; i++) begin
        r = $urandom_range(0, 99);
        op = r < 20 ? 5'd0 : r < 40 ? 5'd1 : r < 60 ? 5'd2 : r < 80 ? 5'd3 : r < 83 ? 5'd4 : 5'($urandom_range(5, 31));
        pm[i] = {op, 11'($urandom)};
        ab[i] = 16'($urandom_range(0, 255));
      end
      q = {};
      p = 16'h0;
      while (q.size() < 300) begin
        w = pm[p];
        op = w[15:11];
        q.push_back(ev(p, 1, 3'd7, 0, 0, 0, 0, 0));
        case (op)
          5'd0: q.push_back(ev(16'h0, 0, 3'd7, 0, 0, 0, 0, 0));
          5'd1: q.push_back(ev(p, 1, 3'd4, 0, 0, 1, 0, 0));
          5'd2: begin
            q.push_back(ev(p, 1, 3'd1, 1, 1, 0, 0, 0));
            q.push_back(ev(p, 1, 3'd2, 0, 1, 1, 0, 0));
          end
          5'd3: q.push_back(ev(p + 16'd1, 1, 3'd5, 0, 0, 0, 0, 0));
          5'd4: begin
            q.push_back(ev(16'h0, 0, 3'd7, 0, 0, 0, 0, 0));
            while (q.size() < 300) q.push_back(ev(16'h0, 0, 3'd7, 0, 0, 0, 1, 0));
          end
          default: q.push_back(ev(16'h0, 0, 3'd7, 0, 0, 0, 0, 1));
        endcase
        p = op == 5'd3 ? ab[p + 16'd1] : p + 16'd1;
      end
      do_reset();
      clr = 1; run = 1;
      for (int i = 0; i < 300; i++) begin
        step();
        m = q[i][8] ? '1 : 25'h1FF;
        n_cmp++;
        if ((v1 & m) !== (q[i] & m)) begin
          n_bad++; $display("FAIL random r%0d cyc %0d: got %h want %h", round, i, v1 & m, q[i] & m);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      pm[i] = '0;
      ab[i] = '0;
    end
    test_reset();
    test_movi();
    test_mov();
    test_jmp_wrap();
    test_illegal_hlt();
    test_reset_mid_mov();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
